// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture controller and its bit/word clock generator.
`timescale 1ns/1ps
package i2s_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        STOPPING = 3'd4
    } ctrl_state_t;

    localparam int FRAME_BCLKS    = 64;
    localparam int SLOT_BCLKS     = 32;
    localparam int BIT_CNT_W      = $clog2(FRAME_BCLKS);
    localparam int DATA_W_DEFAULT = 24;

    // States that are only waiting for the next frame boundary before going idle.
    function automatic logic is_winding_down(ctrl_state_t s);
        return (s == DRAIN) || (s == STOPPING);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Divides the system clock into the I2S bit clock and word-select clock and flags each frame boundary.
`timescale 1ns/1ps
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bclk,
    output logic lrclk,
    output logic frame_start
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BCLKS - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_next;
    logic                 half_done;

    assign half_done = (div_cnt == DIV_LAST);
    assign bit_next  = bit_cnt + 1'b1;

    // Asserted during the cycle whose edge produces the falling bclk that wraps the frame.
    assign frame_start = run && half_done && bclk && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                bit_cnt <= bit_next;
                lrclk   <= bit_next[BIT_CNT_W-1];
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S capture controller: sequences the receiver enable around frame boundaries and
// pairs left/right samples into stereo frames on a valid/ready output.
`timescale 1ns/1ps
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF     = 16,
    parameter int SETTLE_FRAMES = 4,
    parameter int DATA_W        = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              bclk,
    output logic              lrclk,
    output logic              rx_en,
    input  logic              adc_valid_l,
    input  logic              adc_valid_r,
    input  logic [DATA_W-1:0] adc_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

    ctrl_state_t       state;
    logic [7:0]        settle_cnt;
    logic              frame_start;
    logic              going_idle;
    logic              have_left;
    logic [DATA_W-1:0] left_reg;
    logic              pair_done;
    logic              pair_load;
    logic              pair_drop;

    assign busy       = (state != IDLE);
    assign going_idle = is_winding_down(state) && frame_start;

    i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .run         (busy),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .frame_start (frame_start)
    );

    // Every exit to IDLE happens on a frame boundary, so the codec always sees whole frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            rx_en      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state <= STOPPING;
                    end else if (frame_start) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= RUN;
                            rx_en <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (frame_start) begin
                        state <= IDLE;
                        rx_en <= 1'b0;
                    end
                end
                STOPPING: begin
                    if (frame_start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rx_en <= 1'b0;
                end
            endcase
        end
    end

    assign pair_done = rx_en && adc_valid_r && have_left;
    assign pair_load = pair_done && (!out_valid || out_ready);
    assign pair_drop = pair_done && out_valid && !out_ready;

    // A held pair is never disturbed by a newer one; the newer pair is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            have_left <= 1'b0;
            left_reg  <= '0;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            overrun   <= 1'b0;
        end else begin
            if (going_idle) begin
                have_left <= 1'b0;
            end else if (rx_en && adc_valid_l) begin
                left_reg  <= adc_data;
                have_left <= 1'b1;
            end else if (pair_done) begin
                have_left <= 1'b0;
            end

            if (pair_load) begin
                out_left  <= left_reg;
                out_right <= adc_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            overrun <= pair_drop || (overrun && !clr_overrun);
        end
    end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl: random receiver traffic against a frame-arithmetic reference model.
`timescale 1ns/1ps
module tb_i2s_rx_ctrl;

    localparam int BCLK_HALF     = 16;
    localparam int SETTLE_FRAMES = 4;
    localparam int DATA_W        = 24;
    localparam int BCLK_PERIOD   = 2 * BCLK_HALF;
    localparam int SLOT_CLKS     = BCLK_PERIOD * 32;
    localparam int FRAME_CLKS    = BCLK_PERIOD * 64;
    localparam int SETTLE_CLKS   = FRAME_CLKS * SETTLE_FRAMES;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              bclk;
    logic              lrclk;
    logic              rx_en;
    logic              adc_valid_l;
    logic              adc_valid_r;
    logic [DATA_W-1:0] adc_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_left;
    logic [DATA_W-1:0] out_right;
    logic              busy;
    logic              overrun;
    logic              clr_overrun;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    i2s_rx_ctrl #(
        .BCLK_HALF     (BCLK_HALF),
        .SETTLE_FRAMES (SETTLE_FRAMES),
        .DATA_W        (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .rx_en       (rx_en),
        .adc_valid_l (adc_valid_l),
        .adc_valid_r (adc_valid_r),
        .adc_data    (adc_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_left    (out_left),
        .out_right   (out_right),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: clock outputs follow from the number of cycles since start;
    // pairing keeps one pending left sample and one held stereo pair.
    bit                m_active, m_from_settle, m_rx_en;
    int                m_k, m_end;
    bit                m_have_left, m_out_valid, m_overrun;
    logic [DATA_W-1:0] m_left, m_out_l, m_out_r;

    always @(posedge clk) begin : ref_model
        bit rx_pre, idle_now, pair, drop;
        int knew;
        if (!rst) begin
            m_active = 0; m_from_settle = 0; m_rx_en = 0; m_k = 0; m_end = -1;
            m_have_left = 0; m_out_valid = 0; m_overrun = 0;
            m_left = '0; m_out_l = '0; m_out_r = '0;
        end else begin
            rx_pre   = m_rx_en;
            idle_now = 0;
            if (m_active) begin
                knew = m_k + 1;
                if (m_end >= 0 && knew == m_end) begin
                    idle_now = 1;
                end else if (m_end < 0 && stop) begin
                    m_end         = (knew / FRAME_CLKS + 1) * FRAME_CLKS;
                    m_from_settle = (knew <= SETTLE_CLKS);
                end
                m_k = knew;
                if (idle_now) begin
                    m_active = 0; m_k = 0; m_end = -1; m_from_settle = 0;
                end
            end else if (start && !stop) begin
                m_active = 1; m_k = 0; m_end = -1; m_from_settle = 0;
            end
            m_rx_en = m_active && !m_from_settle && (m_k >= SETTLE_CLKS);

            pair = rx_pre && adc_valid_r && m_have_left;
            drop = pair && m_out_valid && !out_ready;
            if (pair && !drop) begin
                m_out_l = m_left; m_out_r = adc_data; m_out_valid = 1;
            end else if (m_out_valid && out_ready) begin
                m_out_valid = 0;
            end
            m_overrun = drop || (m_overrun && !clr_overrun);
            if (pair) m_have_left = 0;
            if (rx_pre && adc_valid_l) begin
                m_left = adc_data; m_have_left = 1;
            end
            if (idle_now) m_have_left = 0;
        end
    end

    function automatic logic [3:0] model_clocks();
        logic b, l;
        b = m_active && (((m_k / BCLK_HALF) % 2) == 1);
        l = m_active && (((m_k / SLOT_CLKS) % 2) == 1);
        return {m_active, m_rx_en, l, b};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("clocks", {60'd0, busy, rx_en, lrclk, bclk}, {60'd0, model_clocks()});
            checkOutput("pairs", {14'd0, out_valid, overrun, out_left, out_right},
                        {14'd0, m_out_valid, m_overrun, m_out_l, m_out_r});
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            out_ready   = ($urandom_range(0, 1) == 1);
            clr_overrun = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic applyStimulus(input bit send_l, input logic [DATA_W-1:0] l,
                                 input bit send_r, input logic [DATA_W-1:0] r, input int gap);
        if (send_l) begin
            adc_data = l; adc_valid_l = 1'b1;
            tick();
            adc_valid_l = 1'b0; adc_data = DATA_W'($urandom);
        end
        repeat (gap) tick();
        if (send_r) begin
            adc_data = r; adc_valid_r = 1'b1;
            tick();
            adc_valid_r = 1'b0; adc_data = DATA_W'($urandom);
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, rise0, rise1, lr0, lr1, edges;
        bit prev_b, prev_l, busy_drop, rx_dropped;
        logic [DATA_W-1:0] l, r;

        rst = 1'b0; start = 0; stop = 0; adc_valid_l = 0; adc_valid_r = 0;
        adc_data = '0; out_ready = 1'b1; clr_overrun = 0;
        tick();
        chk_en = 1'b1;
        checkOutput("reset_state", {58'd0, busy, rx_en, bclk, lrclk, out_valid, overrun}, 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // Start and measure the settle phase; strobes here must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        n = 0; rise0 = -1; rise1 = -1; lr0 = -1; lr1 = -1; prev_b = 0; prev_l = 0; busy_drop = 0;
        while (!rx_en && n < SETTLE_CLKS + 100) begin
            adc_valid_l = (n == 3000);
            adc_valid_r = (n == 3005);
            tick(); n++;
            if (!busy) busy_drop = 1;
            if (bclk && !prev_b) begin
                if (rise0 < 0) rise0 = n; else if (rise1 < 0) rise1 = n;
            end
            if (lrclk != prev_l) begin
                if (lr0 < 0) lr0 = n; else if (lr1 < 0) lr1 = n;
            end
            prev_b = bclk; prev_l = lrclk;
        end
        adc_valid_l = 0; adc_valid_r = 0;
        checkOutput("settle_len", n, SETTLE_CLKS);
        checkOutput("first_bclk_rise", rise0, BCLK_HALF);
        checkOutput("bclk_period", rise1 - rise0, BCLK_PERIOD);
        checkOutput("lrclk_first", lr0, SLOT_CLKS);
        checkOutput("lrclk_half", lr1 - lr0, SLOT_CLKS);
        checkOutput("busy_settle", busy_drop, 0);

        // Basic pair with downstream ready.
        out_ready = 1'b1;
        applyStimulus(1, 24'h123456, 1, 24'hABCDEF, 3);
        checkOutput("pair1_valid", out_valid, 1);
        checkOutput("pair1_left", out_left, 24'h123456);
        checkOutput("pair1_right", out_right, 24'hABCDEF);
        tick();
        checkOutput("pair1_pulse", out_valid, 0);

        // Two pairs with downstream stalled: first is held, second dropped.
        out_ready = 1'b0;
        applyStimulus(1, 24'hA1A2A3, 1, 24'hB1B2B3, 2);
        applyStimulus(1, 24'hC1C2C3, 1, 24'hD1D2D3, 2);
        tick();
        checkOutput("ovr_valid", out_valid, 1);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_held_left", out_left, 24'hA1A2A3);
        checkOutput("ovr_held_right", out_right, 24'hB1B2B3);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);
        checkOutput("ovr_before_pop", out_left, 24'hA1A2A3);
        out_ready = 1'b1; tick(); out_ready = 1'b1;
        checkOutput("ovr_popped", out_valid, 0);
        checkOutput("ovr_pop_right", out_right, 24'hB1B2B3);

        // Orphan right is discarded; the following pair is delivered alone.
        applyStimulus(0, '0, 1, 24'h000111, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("orphan_quiet", out_valid, 0);
            tick();
        end
        applyStimulus(1, 24'h0F0F0F, 1, 24'h00A5A5, 2);
        checkOutput("orphan_pair_left", out_left, 24'h0F0F0F);
        checkOutput("orphan_pair_right", out_right, 24'h00A5A5);
        tick();
        checkOutput("orphan_pair_pulse", out_valid, 0);

        // Random receiver traffic with random backpressure and overrun clears.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            l = DATA_W'($urandom); r = DATA_W'($urandom);
            case ($urandom_range(0, 3))
                0, 1: applyStimulus(1, l, 1, r, $urandom_range(0, 4));
                2:    applyStimulus(0, l, 1, r, $urandom_range(0, 4));
                default: begin
                    applyStimulus(1, r, 0, l, $urandom_range(0, 2));
                    applyStimulus(1, l, 1, r, $urandom_range(0, 4));
                end
            endcase
        end
        rand_mode = 1'b0;
        out_ready = 1'b1; clr_overrun = 1'b1; tick(); clr_overrun = 1'b0; repeat (2) tick();

        // Stop in the middle of a left slot: drains to the frame boundary.
        n = 0;
        while (!lrclk && n < FRAME_CLKS) begin tick(); n++; end
        checkOutput("wait_right_slot", lrclk, 1);
        n = 0;
        while (lrclk && n < FRAME_CLKS) begin tick(); n++; end
        checkOutput("wait_left_slot", lrclk, 0);
        repeat (200) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        n = 0; rx_dropped = 0;
        while (busy && n < 2 * FRAME_CLKS) begin
            if (!rx_en) rx_dropped = 1;
            tick(); n++;
        end
        checkOutput("drain_rx_held", rx_dropped, 0);
        checkOutput("drain_len", n, FRAME_CLKS - 201);
        checkOutput("idle_after_drain", {60'd0, busy, rx_en, bclk, lrclk}, 64'd0);
        edges = 0; prev_b = bclk;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bclk != prev_b) edges++;
            prev_b = bclk;
        end
        checkOutput("idle_no_bclk", edges, 0);

        // Restart, then reset in RUN with a pair held.
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!rx_en && n < SETTLE_CLKS + 100) begin tick(); n++; end
        checkOutput("rerun_rx_en", rx_en, 1);
        out_ready = 1'b0;
        applyStimulus(1, 24'h5A5A5A, 1, 24'h3C3C3C, 1);
        checkOutput("pre_reset_valid", out_valid, 1);
        rst = 1'b0; tick();
        checkOutput("reset_mid_run",
                    {10'd0, busy, rx_en, bclk, lrclk, out_valid, overrun, out_left, out_right}, 64'd0);
        rst = 1'b1;
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        checkOutput("start_stop_idle", {62'd0, busy, bclk}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
- Controller for the I2S capture path.
- Generates the codec bit clock (bclk) and word-select clock (lrclk) from the 100 MHz system clock.
- Sequences the I2S receiver's enable: start, settle, frame-aligned run, and frame-aligned stop.
- Pairs the receiver's left/right 24-bit outputs into stereo frames on a valid/ready interface toward the DSP/FIFO stage.

Parameters:
- BCLK_HALF, 16: clk cycles per bclk half-period (100 MHz / 32 = 3.125 MHz bclk); legal values ≥2.
- SETTLE_FRAMES, 4: full frames clocked with rx_en=0 after start; legal values 1..255.
- DATA_W, 24: sample width, matching the receiver's adc_data.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins capture from IDLE
- stop  in  1  single-cycle pulse; ends capture at the next frame boundary
- bclk  out  1  I2S bit clock to codec and receiver
- lrclk  out  1  I2S word select; 0 = left slot, 1 = right slot
- rx_en  out  1  enable to the I2S receiver
- adc_valid_l  in  1  receiver left sample strobe, 1 clk
- adc_valid_r  in  1  receiver right sample strobe, 1 clk
- adc_data  in  DATA_W  receiver sample, valid with either strobe
- out_valid  out  1  stereo pair available
- out_ready  in  1  downstream accepts the pair
- out_left  out  DATA_W  left sample of the pair
- out_right  out  DATA_W  right sample of the pair
- busy  out  1  state != IDLE
- overrun  out  1  sticky flag: a completed pair was dropped
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset (rst=0 at a clk edge) forces all outputs and internal state to 0 on that edge, including mid-frame: state=IDLE, div_cnt=0, bit_cnt=0, have_left=0. Reset takes priority over everything.
- Clock generation, active only when state != IDLE:
  - div_cnt counts 0..BCLK_HALF-1 and wraps.
  - bclk toggles on the cycle div_cnt==BCLK_HALF-1.
  - On each bclk falling toggle: bit_cnt (6 bits, 0..63) increments modulo 64, and lrclk <= new bit_cnt[5].
  - Frame = 64 bclk = 2048 clk at the defaults; 32 bclk per slot.
  - frame_start = the falling toggle on which bit_cnt wraps 63->0.
- In IDLE: bclk=0, lrclk=0, counters held at 0.
- States:
  - IDLE: start=1 and stop=0 -> SETTLE; settle counter cleared. start and stop together -> stay in IDLE.
  - SETTLE: clocks run, rx_en=0; count frame_starts. stop=1 -> STOPPING. The SETTLE_FRAMES-th frame_start -> RUN, with rx_en=1 from the next cycle.
  - RUN: rx_en=1. stop=1 -> DRAIN. start is ignored.
  - DRAIN: rx_en stays 1 until the next frame_start, then -> IDLE with rx_en=0. The final right slot is therefore complete.
  - STOPPING: stays until the next frame_start, then -> IDLE.
  - On entry to IDLE, bclk is already 0 (the transition happens on a falling toggle).
- start is ignored outside IDLE. stop is ignored in IDLE, DRAIN and STOPPING.
- Pairing:
  - adc_valid_l: left_reg <= adc_data, have_left <= 1. A second left overwrites the first.
  - adc_valid_r with have_left=1 completes a pair. Right without have_left is an orphan and is discarded silently.
  - When a pair completes:
    - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: on the next cycle out_left/out_right are loaded, out_valid=1, have_left=0.
    - If out_valid=1 and out_ready=0: the new pair is dropped, the held pair stays stable, overrun <= 1, have_left <= 0.
- out_valid clears after a cycle with out_valid & out_ready and no new pair completing. Outputs hold stable while out_valid=1 and out_ready=0.
- Strobes arriving while rx_en=0 are ignored. have_left clears on entry to IDLE.
- overrun: set has priority over clr_overrun in the same cycle.
- busy is combinational from the state register. All other outputs are registered.

Decomposition:
- Shared package i2s_pkg holds:
  - state encoding IDLE/SETTLE/RUN/DRAIN/STOPPING
  - FRAME_BCLKS=64 and SLOT_BCLKS=32
  - DATA_W default
- One natural sub-module: i2s_clkgen. It contains div_cnt, bit_cnt, bclk, lrclk, and a frame_start strobe, gated by a run input. The FSM and pairing logic stay in i2s_rx_ctrl.

Test Plan:
- Reset then start pulse at defaults -> bclk period exactly 32 clk; lrclk toggles every 1024 clk; rx_en rises one cycle after the 4th frame_start (≈8192 clk after the clocks start); busy=1 throughout.
- Receiver model sends L=0x123456 then R=0xABCDEF, out_ready=1 -> out_valid pulses 1 cycle with out_left=0x123456, out_right=0xABCDEF.
- out_ready=0 across two complete pairs -> first pair held stable, overrun=1; clr_overrun -> overrun=0; pulsing out_ready then yields the first pair, not the second.
- Stop pulse mid-left-slot in RUN -> rx_en stays 1 through the right slot and falls at frame_start; bclk=0, lrclk=0, busy=0 afterwards; no bclk edges until the next start.
- Orphan right (R=0x000111 with no prior L) followed by a normal L/R pair -> no output for the orphan; the single output pair equals the L/R pair.
- rst=0 asserted mid-RUN with out_valid=1 -> on the next edge all outputs are 0 and the state is IDLE; start with stop in the same cycle -> remains IDLE.
